// File: rtl/if_id_stage_p.sv
// IF/ID pipeline register with stall hold, flush bubbles and a flush shadow
// that masks stale instruction-memory read data for FLUSH_LAT extra cycles.
module if_id_stage_p #(
    parameter int                 ADDR_W    = 32,
    parameter int                 INSTR_W   = 32,
    parameter int                 FLUSH_LAT = 1,
    parameter logic [INSTR_W-1:0] NOP       = INSTR_W'(32'h00000013),
    parameter int                 CNT_W     = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               F_stall,
    input  logic               D_flush,
    input  logic               F_valid,
    input  logic [ADDR_W-1:0]  F_pc,
    input  logic [INSTR_W-1:0] F_instr,
    input  logic [ADDR_W-1:0]  F_pc_plus_4,
    input  logic               cnt_clr,
    output logic               D_valid,
    output logic [ADDR_W-1:0]  D_pc,
    output logic [INSTR_W-1:0] D_instr,
    output logic [ADDR_W-1:0]  D_pc_plus_4,
    output logic               flush_busy,
    output logic [CNT_W-1:0]   bubble_cnt
);

    logic shadow;
    logic kill;
    logic bubble;

    generate
        if (FLUSH_LAT > 0) begin : g_shadow
            logic [3:0] sh_cnt;

            // A new flush restarts the shadow rather than extending it by a sum.
            always_ff @(posedge clk) begin
                if (rst)
                    sh_cnt <= 4'd0;
                else if (D_flush)
                    sh_cnt <= 4'(FLUSH_LAT);
                else if (sh_cnt != 4'd0)
                    sh_cnt <= sh_cnt - 4'd1;
            end

            assign shadow = (sh_cnt != 4'd0);
        end else begin : g_no_shadow
            assign shadow = 1'b0;
        end
    endgenerate

    assign kill       = D_flush | shadow;
    assign bubble     = kill | (!F_stall && !F_valid);
    assign flush_busy = shadow;

    always_ff @(posedge clk) begin
        if (rst) begin
            D_valid     <= 1'b0;
            D_pc        <= '0;
            D_instr     <= NOP;
            D_pc_plus_4 <= '0;
        end else if (bubble) begin
            D_valid     <= 1'b0;
            D_pc        <= '0;
            D_instr     <= NOP;
            D_pc_plus_4 <= '0;
        end else if (!F_stall) begin
            D_valid     <= 1'b1;
            D_pc        <= F_pc;
            D_instr     <= F_instr;
            D_pc_plus_4 <= F_pc_plus_4;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || cnt_clr)
            bubble_cnt <= '0;
        else if (bubble && bubble_cnt != '1)
            bubble_cnt <= bubble_cnt + CNT_W'(1);
    end

endmodule

// File: tb/tb_if_id_stage_p.sv
// Bench for if_id_stage_p: four instances with different FLUSH_LAT/CNT_W
// share stimulus; expected D_* state is queued per edge and compared after it.
module tb_if_id_stage_p;

    typedef struct packed {
        logic        v;
        logic [31:0] pc;
        logic [31:0] ins;
        logic [31:0] pc4;
        logic        busy;
        logic [15:0] cnt;
    } exp_t;

    typedef struct {
        logic        r, st, fl, v, clr;
        logic [31:0] pc;
        logic        ev;
        logic [31:0] epc;
        logic        eb;
        int          ec;
    } row_t;

    logic        clk = 1'b0;
    logic        rst, F_stall, D_flush, F_valid, cnt_clr;
    logic [31:0] F_pc, F_instr, F_pc_plus_4;

    logic        v_o[4];
    logic [31:0] pc_o[4], ins_o[4], p4_o[4];
    logic        busy_o[4];
    logic [15:0] cnt_o[4];
    logic [3:0]  cnt_small;

    int   sel = 0;
    exp_t obs;
    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    // index 0: FLUSH_LAT=1, 1: FLUSH_LAT=3, 2: FLUSH_LAT=5 CNT_W=4, 3: FLUSH_LAT=0
    if_id_stage_p #(.FLUSH_LAT(1)) d1 (
        .clk(clk), .rst(rst), .F_stall(F_stall), .D_flush(D_flush),
        .F_valid(F_valid), .F_pc(F_pc), .F_instr(F_instr),
        .F_pc_plus_4(F_pc_plus_4), .cnt_clr(cnt_clr),
        .D_valid(v_o[0]), .D_pc(pc_o[0]), .D_instr(ins_o[0]),
        .D_pc_plus_4(p4_o[0]), .flush_busy(busy_o[0]), .bubble_cnt(cnt_o[0]));

    if_id_stage_p #(.FLUSH_LAT(3)) d3 (
        .clk(clk), .rst(rst), .F_stall(F_stall), .D_flush(D_flush),
        .F_valid(F_valid), .F_pc(F_pc), .F_instr(F_instr),
        .F_pc_plus_4(F_pc_plus_4), .cnt_clr(cnt_clr),
        .D_valid(v_o[1]), .D_pc(pc_o[1]), .D_instr(ins_o[1]),
        .D_pc_plus_4(p4_o[1]), .flush_busy(busy_o[1]), .bubble_cnt(cnt_o[1]));

    if_id_stage_p #(.FLUSH_LAT(5), .CNT_W(4)) d5 (
        .clk(clk), .rst(rst), .F_stall(F_stall), .D_flush(D_flush),
        .F_valid(F_valid), .F_pc(F_pc), .F_instr(F_instr),
        .F_pc_plus_4(F_pc_plus_4), .cnt_clr(cnt_clr),
        .D_valid(v_o[2]), .D_pc(pc_o[2]), .D_instr(ins_o[2]),
        .D_pc_plus_4(p4_o[2]), .flush_busy(busy_o[2]), .bubble_cnt(cnt_small));

    assign cnt_o[2] = {12'h000, cnt_small};

    if_id_stage_p #(.FLUSH_LAT(0)) d0 (
        .clk(clk), .rst(rst), .F_stall(F_stall), .D_flush(D_flush),
        .F_valid(F_valid), .F_pc(F_pc), .F_instr(F_instr),
        .F_pc_plus_4(F_pc_plus_4), .cnt_clr(cnt_clr),
        .D_valid(v_o[3]), .D_pc(pc_o[3]), .D_instr(ins_o[3]),
        .D_pc_plus_4(p4_o[3]), .flush_busy(busy_o[3]), .bubble_cnt(cnt_o[3]));

    always_comb begin
        obs = '0;
        if (sel >= 0 && sel < 4)
            obs = {v_o[sel], pc_o[sel], ins_o[sel], p4_o[sel],
                   busy_o[sel], cnt_o[sel]};
    end

    function automatic logic [31:0] instr_of(input logic [31:0] pc);
        return {pc[19:0], 12'h0b3};
    endfunction

    function automatic row_t row(input logic r, st, fl, v, clr,
                                 input logic [31:0] pc, input logic ev,
                                 input logic [31:0] epc, input logic eb,
                                 input int ec);
        row_t x;
        x.r = r; x.st = st; x.fl = fl; x.v = v; x.clr = clr; x.pc = pc;
        x.ev = ev; x.epc = epc; x.eb = eb; x.ec = ec;
        return x;
    endfunction

    function automatic exp_t mk(input logic ev, input logic [31:0] epc,
                                input logic eb, input int ec);
        exp_t e;
        e.v    = ev;
        e.pc   = ev ? epc : 32'h0;
        e.ins  = ev ? instr_of(epc) : 32'h00000013;
        e.pc4  = ev ? epc + 32'd4 : 32'h0;
        e.busy = eb;
        e.cnt  = 16'(ec);
        return e;
    endfunction

    function automatic string fmt(input exp_t e);
        return $sformatf("v=%0b pc=%h ins=%h pc4=%h busy=%0b cnt=%0d",
                         e.v, e.pc, e.ins, e.pc4, e.busy, e.cnt);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input row_t x);
        rst         = x.r;
        F_stall     = x.st;
        D_flush     = x.fl;
        F_valid     = x.v;
        cnt_clr     = x.clr;
        F_pc        = x.pc;
        F_instr     = instr_of(x.pc);
        F_pc_plus_4 = x.pc + 32'd4;
    endtask

    task automatic do_reset();
        apply(row(1, 0, 0, 0, 0, 32'h0, 0, 0, 0, 0));
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        exp_t e;
        for (int c = 0; c < 2; c++) begin
            rst         = 1'b1;
            F_stall     = 1'($urandom);
            D_flush     = 1'($urandom);
            F_valid     = 1'($urandom);
            cnt_clr     = 1'($urandom);
            F_pc        = $urandom;
            F_instr     = $urandom;
            F_pc_plus_4 = $urandom;
            for (int s = 0; s < 4; s++) sb.push_back(mk(0, 0, 0, 0));
            tick();
            for (int s = 0; s < 4; s++) begin
                sel = s;
                #1;
                e = sb.pop_front();
                n_cmp++;
                if (obs !== e) begin
                    n_bad++;
                    $display("FAIL reset inst%0d cyc%0d got %s want %s",
                             s, c, fmt(obs), fmt(e));
                end
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_stream();
        row_t t[$];
        exp_t e;
        sel = 0;
        t.push_back(row(0, 0, 0, 1, 0, 32'h100, 1, 32'h100, 0, 0));
        t.push_back(row(0, 0, 0, 1, 0, 32'h104, 1, 32'h104, 0, 0));
        t.push_back(row(0, 0, 0, 1, 0, 32'h108, 1, 32'h108, 0, 0));
        foreach (t[i]) begin
            apply(t[i]);
            sb.push_back(mk(t[i].ev, t[i].epc, t[i].eb, t[i].ec));
            tick();
            e = sb.pop_front();
            n_cmp++;
            if (obs !== e) begin
                n_bad++;
                $display("FAIL stream[%0d] got %s want %s", i, fmt(obs), fmt(e));
            end
        end
    endtask

    task automatic test_flush_shadow();
        row_t t[$];
        exp_t e;
        sel = 1;
        do_reset();
        t.push_back(row(0, 0, 1, 1, 0, 32'h1f0, 0, 0, 1, 1));
        t.push_back(row(0, 0, 0, 1, 0, 32'h1f4, 0, 0, 1, 2));
        t.push_back(row(0, 0, 0, 1, 0, 32'h1f8, 0, 0, 1, 3));
        t.push_back(row(0, 0, 0, 1, 0, 32'h1fc, 0, 0, 0, 4));
        t.push_back(row(0, 0, 0, 1, 0, 32'h200, 1, 32'h200, 0, 4));
        foreach (t[i]) begin
            apply(t[i]);
            sb.push_back(mk(t[i].ev, t[i].epc, t[i].eb, t[i].ec));
            tick();
            e = sb.pop_front();
            n_cmp++;
            if (obs !== e) begin
                n_bad++;
                $display("FAIL flush_shadow[%0d] got %s want %s", i, fmt(obs), fmt(e));
            end
        end
    endtask

    task automatic test_stall_flush();
        row_t t[$];
        exp_t e;
        sel = 1;
        do_reset();
        t.push_back(row(0, 0, 0, 1, 0, 32'h100, 1, 32'h100, 0, 0));
        t.push_back(row(0, 0, 0, 1, 0, 32'h104, 1, 32'h104, 0, 0));
        for (int k = 0; k < 3; k++)
            t.push_back(row(0, 1, 0, 1, 0, 32'h108, 1, 32'h104, 0, 0));
        t.push_back(row(0, 1, 1, 1, 0, 32'h108, 0, 0, 1, 1));
        t.push_back(row(0, 0, 1, 1, 0, 32'h300, 0, 0, 1, 2));
        t.push_back(row(0, 0, 0, 1, 0, 32'h300, 0, 0, 1, 3));
        t.push_back(row(0, 0, 0, 1, 0, 32'h300, 0, 0, 1, 4));
        t.push_back(row(0, 1, 0, 1, 0, 32'h300, 0, 0, 0, 5));
        t.push_back(row(0, 1, 0, 1, 0, 32'h300, 0, 0, 0, 5));
        t.push_back(row(0, 0, 0, 1, 0, 32'h300, 1, 32'h300, 0, 5));
        foreach (t[i]) begin
            apply(t[i]);
            sb.push_back(mk(t[i].ev, t[i].epc, t[i].eb, t[i].ec));
            tick();
            e = sb.pop_front();
            n_cmp++;
            if (obs !== e) begin
                n_bad++;
                $display("FAIL stall_flush[%0d] got %s want %s", i, fmt(obs), fmt(e));
            end
        end
    endtask

    task automatic test_invalid_count();
        row_t t[$];
        exp_t e;
        sel = 2;
        do_reset();
        for (int k = 0; k < 20; k++)
            t.push_back(row(0, 0, 0, 0, 0, 32'h600 + 32'(4 * k), 0, 0, 0,
                            (k + 1 > 15) ? 15 : k + 1));
        t.push_back(row(0, 0, 0, 0, 1, 32'h700, 0, 0, 0, 0));
        t.push_back(row(0, 0, 0, 0, 0, 32'h704, 0, 0, 0, 1));
        t.push_back(row(0, 1, 0, 0, 0, 32'h708, 0, 0, 0, 1));
        t.push_back(row(0, 1, 1, 0, 0, 32'h70c, 0, 0, 1, 2));
        foreach (t[i]) begin
            apply(t[i]);
            sb.push_back(mk(t[i].ev, t[i].epc, t[i].eb, t[i].ec));
            tick();
            e = sb.pop_front();
            n_cmp++;
            if (obs !== e) begin
                n_bad++;
                $display("FAIL invalid_count[%0d] got %s want %s", i, fmt(obs), fmt(e));
            end
        end
    endtask

    task automatic test_reset_mid_shadow();
        row_t t[$];
        exp_t e;
        sel = 2;
        do_reset();
        t.push_back(row(0, 0, 1, 1, 0, 32'h400, 0, 0, 1, 1));
        t.push_back(row(0, 0, 0, 1, 0, 32'h400, 0, 0, 1, 2));
        t.push_back(row(1, 0, 0, 1, 0, 32'h400, 0, 0, 0, 0));
        t.push_back(row(0, 0, 0, 1, 0, 32'h404, 1, 32'h404, 0, 0));
        foreach (t[i]) begin
            apply(t[i]);
            sb.push_back(mk(t[i].ev, t[i].epc, t[i].eb, t[i].ec));
            tick();
            e = sb.pop_front();
            n_cmp++;
            if (obs !== e) begin
                n_bad++;
                $display("FAIL reset_mid_shadow[%0d] got %s want %s", i, fmt(obs), fmt(e));
            end
        end
    endtask

    task automatic test_flush_lat0();
        row_t t[$];
        exp_t e;
        sel = 3;
        do_reset();
        t.push_back(row(0, 0, 1, 1, 0, 32'h500, 0, 0, 0, 1));
        t.push_back(row(0, 0, 0, 1, 0, 32'h504, 1, 32'h504, 0, 1));
        foreach (t[i]) begin
            apply(t[i]);
            sb.push_back(mk(t[i].ev, t[i].epc, t[i].eb, t[i].ec));
            tick();
            e = sb.pop_front();
            n_cmp++;
            if (obs !== e) begin
                n_bad++;
                $display("FAIL flush_lat0[%0d] got %s want %s", i, fmt(obs), fmt(e));
            end
        end
    endtask

    initial begin
        apply(row(1, 0, 0, 0, 0, 32'h0, 0, 0, 0, 0));
        tick();
        test_reset();
        test_stream();
        test_flush_shadow();
        test_stall_flush();
        test_invalid_count();
        test_reset_mid_shadow();
        test_flush_lat0();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/if_id_stage_p.md
# if_id_stage_p

Parametrised IF/ID pipeline stage register with a configurable flush shadow that covers instruction-memory read latency. It sits between the fetch stage and decode in the pipelined core. It captures PC, instruction and PC+4 from fetch and holds them under stall. It inserts NOP bubbles on flush, and keeps inserting them for FLUSH_LAT further cycles so that stale synchronous-BRAM read data never reaches decode. It also tracks a valid bit and a saturating bubble counter for performance monitoring.

## Interface
- ADDR_W, 32, width of the PC and PC+4 fields
- INSTR_W, 32, width of the instruction field
- FLUSH_LAT, 1, extra bubble cycles after a flush cycle; legal range 0..15
- NOP, 32'h00000013, bubble instruction (addi x0,x0,0), INSTR_W bits
- CNT_W, 16, width of the bubble counter
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset; synchronous, active-high
- F_stall  in  1  hold D_* at current values
- D_flush  in  1  squash the incoming fetch and start the flush shadow
- F_valid  in  1  fetch data valid this cycle
- F_pc  in  ADDR_W  fetch PC
- F_instr  in  INSTR_W  fetched instruction
- F_pc_plus_4  in  ADDR_W  fetch PC+4
- cnt_clr  in  1  clear bubble_cnt
- D_valid  out  1  decode-stage contents are a real instruction
- D_pc  out  ADDR_W  decode PC
- D_instr  out  INSTR_W  decode instruction
- D_pc_plus_4  out  ADDR_W  decode PC+4
- flush_busy  out  1  flush shadow active (shadow counter non-zero)
- bubble_cnt  out  CNT_W  count of bubbles loaded, saturating

## Operation
- Shadow counter sh_cnt is 4 bits (or absent when FLUSH_LAT=0).
  - On D_flush it loads FLUSH_LAT.
  - Otherwise, if non-zero, it decrements by 1.
  - It decrements every cycle regardless of F_stall.
- kill = D_flush | (sh_cnt != 0).
- Per-edge priority, highest first:
  - rst: all outputs to their reset values; sh_cnt to 0.
  - kill: load a bubble (D_instr=NOP, D_pc=0, D_pc_plus_4=0, D_valid=0).
  - F_stall: hold all D_* unchanged.
  - !F_valid: load a bubble.
  - Otherwise: load F_pc, F_instr, F_pc_plus_4 and set D_valid=1.
- Flush overrides stall. A flush arriving while stalled still squashes the held instruction.
- D_flush during an active shadow reloads sh_cnt to FLUSH_LAT. The shadow is extended, never summed.
- flush_busy = (sh_cnt != 0). It is decoded directly from the register, with no combinational path from inputs.
- bubble_cnt:
  - Increments by 1 on each edge where a bubble is loaded (kill, or !F_valid while not stalled).
  - Holds at all-ones once saturated.
  - cnt_clr forces it to 0 and takes priority over increment.
  - Stall-hold cycles are not counted.
- Reset values: D_instr=NOP, D_pc=0, D_pc_plus_4=0, D_valid=0, flush_busy=0, bubble_cnt=0.

## Timing
- All outputs are registered. Fetch data presented before edge N appears on D_* after edge N (1-cycle latency).
- D_flush high before edge N:
  - Bubble after edge N.
  - Bubbles also after edges N+1 .. N+FLUSH_LAT.
  - First real instruction possible after edge N+FLUSH_LAT+1.
- flush_busy is high from after edge N to after edge N+FLUSH_LAT-1, i.e. FLUSH_LAT cycles. It is never high when FLUSH_LAT=0.
- FLUSH_LAT=0 gives a single-cycle flush only.
- FLUSH_LAT=1 reproduces the original one-extra-cycle BRAM flush.
- If F_stall is high when the shadow expires, D_* holds the last bubble (D_valid=0) until the stall releases.
- rst asserted mid-shadow: sh_cnt=0 after that edge. Normal loading resumes on the first edge after rst deasserts.
- Simultaneous D_flush, F_stall and !F_valid: bubble loaded, counted once.

## Test plan
- Reset: rst high 2 cycles with random inputs -> D_instr=0x00000013, D_pc=0, D_pc_plus_4=0, D_valid=0, flush_busy=0, bubble_cnt=0.
- Streaming, FLUSH_LAT=1: F_valid=1, F_pc=0x100, 0x104, 0x108 on consecutive cycles -> D_pc follows one cycle later, D_pc_plus_4=D_pc+4, D_valid=1, bubble_cnt stays 0.
- Flush shadow, FLUSH_LAT=3: D_flush pulsed 1 cycle -> 4 consecutive bubbles (D_valid=0, D_instr=NOP), flush_busy high for 3 cycles, bubble_cnt=4, then F_pc=0x200 appears.
- Stall/flush interaction: hold F_stall with D_pc=0x104 for 3 cycles -> D_pc stays 0x104; then pulse D_flush while still stalled -> bubble loaded next edge despite stall; a D_flush reissued 1 cycle into a FLUSH_LAT=3 shadow restarts it (5 total bubbles).
- Invalid fetch and counter: F_valid=0 for 2 unstalled cycles -> 2 bubbles, bubble_cnt+=2; CNT_W=4 with 20 bubbles -> bubble_cnt=15 (saturated); cnt_clr together with a bubble -> bubble_cnt=0.
- Reset mid-shadow, FLUSH_LAT=5: rst 2 cycles after the flush -> flush_busy=0, and the first valid fetch after rst deasserts reaches D_* with D_valid=1.
